// File: rtl/apb_master_arbiter_pkg.sv
// Shared definitions for the APB master arbiter.
// - apb_state_e: transfer sequencer states (IDLE -> SETUP -> ACCESS -> IDLE).
// - DEF_*: default parameter values for the arbiter top.
package apb_master_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2
  } apb_state_e;

  localparam int DEF_NUM_REQ = 2;
  localparam int DEF_ADDR_W  = 32;
  localparam int DEF_DATA_W  = 32;
  localparam int DEF_SEL_W   = 3;
  localparam int DEF_TIMEOUT = 16;

endpackage

// File: rtl/apb_master_arbiter_rr_arbiter.sv
// Combinational round-robin picker.
// Ports:
//   req_i   - candidate request vector
//   ptr_i   - highest-priority index this round
//   gnt_o   - one-hot winner (0 when no candidate)
//   idx_o   - binary index of the winner
//   valid_o - at least one candidate present
// The first set bit at or after ptr_i wins, wrapping NUM_REQ-1 -> 0.
module apb_master_arbiter_rr_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int IDX_W   = 1
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IDX_W-1:0]   ptr_i,
  output logic [NUM_REQ-1:0] gnt_o,
  output logic [IDX_W-1:0]   idx_o,
  output logic               valid_o
);

  always_comb begin
    // NOTE: every signal written here gets a value before any branch, so no
    // path leaves it unassigned and no latch is inferred.
    gnt_o   = '0;
    idx_o   = '0;
    valid_o = 1'b0;
    for (int off = 0; off < NUM_REQ; off++) begin
      logic [IDX_W-1:0] cand;
      cand = IDX_W'((int'(ptr_i) + off) % NUM_REQ);
      if (!valid_o && req_i[cand]) begin
        valid_o     = 1'b1;
        gnt_o[cand] = 1'b1;
        idx_o       = cand;
      end
    end
  end

endmodule

// File: rtl/apb_master_arbiter.sv
// Shares one APB master port between NUM_REQ requesters.
// Round-robin arbitration per transfer, then a SETUP/ACCESS APB sequence for
// the winner, with PREADY wait states and an abort after TIMEOUT wait cycles.
// Ports:
//   hclk, hresetn                     - clock, async active-low reset
//   req_valid/write/addr/wdata/sel    - flattened per-requester requests
//   req_done, req_err, req_rdata      - completion pulse + status to the owner
//   grant                             - one-hot current owner, 0 when idle
//   psel/penable/pwrite/paddr/pwdata  - APB request side (all registered)
//   prdata/pready/pslverr             - APB response side
// A transfer that sees pready=0 for TIMEOUT consecutive ACCESS cycles is
// completed with req_err=1 on the edge that ends the last of those cycles.
module apb_master_arbiter
  import apb_master_arbiter_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ,
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int DATA_W  = DEF_DATA_W,
  parameter int SEL_W   = DEF_SEL_W,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic                      hclk,
  input  logic                      hresetn,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ-1:0]        req_write,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
  input  logic [NUM_REQ*SEL_W-1:0]  req_sel,
  output logic [NUM_REQ-1:0]        req_done,
  output logic                      req_err,
  output logic [DATA_W-1:0]         req_rdata,
  output logic [NUM_REQ-1:0]        grant,
  output logic [SEL_W-1:0]          psel,
  output logic                      penable,
  output logic                      pwrite,
  output logic [ADDR_W-1:0]         paddr,
  output logic [DATA_W-1:0]         pwdata,
  input  logic [DATA_W-1:0]         prdata,
  input  logic                      pready,
  input  logic                      pslverr
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CNT_W = $clog2(TIMEOUT + 1);

  apb_state_e state_q, state_d;
  logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [IDX_W-1:0]   owner_q, owner_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [NUM_REQ-1:0] grant_q, grant_d;
  logic [SEL_W-1:0]   psel_q, psel_d;
  logic               penable_q, penable_d;
  logic               pwrite_q, pwrite_d;
  logic [ADDR_W-1:0]  paddr_q, paddr_d;
  logic [DATA_W-1:0]  pwdata_q, pwdata_d;
  logic [NUM_REQ-1:0] req_done_q, req_done_d;
  logic               req_err_q, req_err_d;
  logic [DATA_W-1:0]  req_rdata_q, req_rdata_d;

  // Unpacked views of the flattened request buses.
  logic [ADDR_W-1:0] addr_arr  [NUM_REQ];
  logic [DATA_W-1:0] wdata_arr [NUM_REQ];
  logic [SEL_W-1:0]  sel_arr   [NUM_REQ];

  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      addr_arr[i]  = req_addr[i*ADDR_W +: ADDR_W];
      wdata_arr[i] = req_wdata[i*DATA_W +: DATA_W];
      sel_arr[i]   = req_sel[i*SEL_W +: SEL_W];
    end
  end

  // req_done_q is one-hot on the previous owner during the done cycle, so it
  // doubles as the mask that stops a requester being re-granted before it has
  // had a chance to drop req_valid.
  logic [NUM_REQ-1:0] arb_req, arb_gnt;
  logic [IDX_W-1:0]   arb_idx;
  logic               arb_valid;

  assign arb_req = req_valid & ~req_done_q;

  apb_master_arbiter_rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr_arbiter (
    .req_i   (arb_req),
    .ptr_i   (rr_ptr_q),
    .gnt_o   (arb_gnt),
    .idx_o   (arb_idx),
    .valid_o (arb_valid)
  );

  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    owner_d     = owner_q;
    cnt_d       = cnt_q;
    grant_d     = grant_q;
    psel_d      = psel_q;
    penable_d   = penable_q;
    pwrite_d    = pwrite_q;
    paddr_d     = paddr_q;
    pwdata_d    = pwdata_q;
    req_done_d  = '0;
    req_err_d   = 1'b0;
    req_rdata_d = '0;

    unique case (state_q)
      ST_IDLE: begin
        if (arb_valid) begin
          state_d  = ST_SETUP;
          owner_d  = arb_idx;
          grant_d  = arb_gnt;
          cnt_d    = '0;
          psel_d   = sel_arr[arb_idx];
          pwrite_d = req_write[arb_idx];
          paddr_d  = addr_arr[arb_idx];
          pwdata_d = wdata_arr[arb_idx];
        end
      end
      ST_SETUP: begin
        state_d   = ST_ACCESS;
        penable_d = 1'b1;
      end
      ST_ACCESS: begin
        if (pready || (cnt_q == CNT_W'(TIMEOUT - 1))) begin
          state_d     = ST_IDLE;
          psel_d      = '0;
          penable_d   = 1'b0;
          grant_d     = '0;
          req_done_d  = grant_q;
          req_err_d   = pready ? pslverr : 1'b1;
          req_rdata_d = (pready && !pwrite_q) ? prdata : '0;
          rr_ptr_d    = (owner_q == IDX_W'(NUM_REQ - 1)) ? '0 : owner_q + IDX_W'(1);
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      state_q     <= ST_IDLE;
      rr_ptr_q    <= '0;
      owner_q     <= '0;
      cnt_q       <= '0;
      grant_q     <= '0;
      psel_q      <= '0;
      penable_q   <= 1'b0;
      pwrite_q    <= 1'b0;
      paddr_q     <= '0;
      pwdata_q    <= '0;
      req_done_q  <= '0;
      req_err_q   <= 1'b0;
      req_rdata_q <= '0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples the pre-edge
      // value of its inputs regardless of statement order.
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      owner_q     <= owner_d;
      cnt_q       <= cnt_d;
      grant_q     <= grant_d;
      psel_q      <= psel_d;
      penable_q   <= penable_d;
      pwrite_q    <= pwrite_d;
      paddr_q     <= paddr_d;
      pwdata_q    <= pwdata_d;
      req_done_q  <= req_done_d;
      req_err_q   <= req_err_d;
      req_rdata_q <= req_rdata_d;
    end
  end

  assign req_done  = req_done_q;
  assign req_err   = req_err_q;
  assign req_rdata = req_rdata_q;
  assign grant     = grant_q;
  assign psel      = psel_q;
  assign penable   = penable_q;
  assign pwrite    = pwrite_q;
  assign paddr     = paddr_q;
  assign pwdata    = pwdata_q;

endmodule

// File: tb/tb_apb_master_arbiter.sv
// Self-checking bench for apb_master_arbiter: directed scenarios plus a
// randomized run, all checked against a transfer-level reference model.
module tb_apb_master_arbiter;

  localparam int NUM_REQ = 2;
  localparam int ADDR_W  = 32;
  localparam int DATA_W  = 32;
  localparam int SEL_W   = 3;
  localparam int TIMEOUT = 16;

  logic                      hclk = 1'b0;
  logic                      hresetn;
  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ-1:0]        req_write;
  logic [NUM_REQ*ADDR_W-1:0] req_addr;
  logic [NUM_REQ*DATA_W-1:0] req_wdata;
  logic [NUM_REQ*SEL_W-1:0]  req_sel;
  logic [NUM_REQ-1:0]        req_done;
  logic                      req_err;
  logic [DATA_W-1:0]         req_rdata;
  logic [NUM_REQ-1:0]        grant;
  logic [SEL_W-1:0]          psel;
  logic                      penable;
  logic                      pwrite;
  logic [ADDR_W-1:0]         paddr;
  logic [DATA_W-1:0]         pwdata;
  logic [DATA_W-1:0]         prdata;
  logic                      pready;
  logic                      pslverr;

  apb_master_arbiter #(
    .NUM_REQ (NUM_REQ),
    .ADDR_W  (ADDR_W),
    .DATA_W  (DATA_W),
    .SEL_W   (SEL_W),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .hclk      (hclk),
    .hresetn   (hresetn),
    .req_valid (req_valid),
    .req_write (req_write),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .req_sel   (req_sel),
    .req_done  (req_done),
    .req_err   (req_err),
    .req_rdata (req_rdata),
    .grant     (grant),
    .psel      (psel),
    .penable   (penable),
    .pwrite    (pwrite),
    .paddr     (paddr),
    .pwdata    (pwdata),
    .prdata    (prdata),
    .pready    (pready),
    .pslverr   (pslverr)
  );

  always #5 hclk = ~hclk;

  int checks   = 0;
  int failures = 0;

  // Reference model: pending requests per requester and the round-robin state.
  bit                 pend_m  [NUM_REQ];
  bit                 wr_m    [NUM_REQ];
  logic [ADDR_W-1:0]  addr_m  [NUM_REQ];
  logic [DATA_W-1:0]  wdata_m [NUM_REQ];
  logic [SEL_W-1:0]   sel_m   [NUM_REQ];
  int                 model_ptr = 0;
  logic [NUM_REQ-1:0] mask_m = '0;
  int                 last_win = -1;

  // Slave behaviour: pready rises after slave_waits ACCESS cycles (-1 = never).
  int                slave_waits = -1;
  logic [DATA_W-1:0] slave_rdata = '0;
  bit                slave_err   = 1'b0;
  int                acc_cnt     = 0;

  initial begin
    pready  = 1'b0;
    prdata  = '0;
    pslverr = 1'b0;
    forever begin
      @(negedge hclk);
      if (psel != '0 && penable) begin
        pready = (slave_waits >= 0) && (acc_cnt >= slave_waits);
        acc_cnt++;
      end else begin
        pready  = 1'b0;
        acc_cnt = 0;
      end
      prdata  = slave_rdata;
      pslverr = pready & slave_err;
    end
  end

  function automatic logic [NUM_REQ-1:0] pend_vec();
    logic [NUM_REQ-1:0] v;
    v = '0;
    for (int i = 0; i < NUM_REQ; i++) v[i] = pend_m[i];
    return v;
  endfunction

  // First candidate at or after ptr, wrapping around.
  function automatic int pick(input logic [NUM_REQ-1:0] c, input int ptr);
    for (int k = 0; k < NUM_REQ; k++)
      if (c[(ptr + k) % NUM_REQ]) return (ptr + k) % NUM_REQ;
    return -1;
  endfunction

  task automatic apply_reqs();
    for (int i = 0; i < NUM_REQ; i++) begin
      req_valid[i]                  = pend_m[i];
      req_write[i]                  = wr_m[i];
      req_addr[i*ADDR_W +: ADDR_W]  = addr_m[i];
      req_wdata[i*DATA_W +: DATA_W] = wdata_m[i];
      req_sel[i*SEL_W +: SEL_W]     = sel_m[i];
    end
  endtask

  task automatic new_req(input int i);
    pend_m[i]  = 1'b1;
    wr_m[i]    = 1'($urandom_range(0, 1));
    addr_m[i]  = $urandom & ~32'h3;
    wdata_m[i] = $urandom;
    sel_m[i]   = SEL_W'(1) << $urandom_range(0, SEL_W - 1);
  endtask

  task automatic do_reset();
    @(negedge hclk);
    hresetn = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) pend_m[i] = 1'b0;
    apply_reqs();
    repeat (2) @(negedge hclk);
    hresetn   = 1'b1;
    model_ptr = 0;
    mask_m    = '0;
  endtask

  // Runs one transfer from the negedge just before the sampling IDLE edge up
  // to the negedge that shows req_done, checking every cycle in between.
  task automatic run_xfer(input int waits, input bit tmo, input bit err,
                          input logic [DATA_W-1:0] rd, input bit scramble,
                          input string tag);
    logic [NUM_REQ-1:0] cands, oh;
    int                 win, nw;
    logic               exp_err;
    logic [DATA_W-1:0]  exp_rd;
    cands = pend_vec() & ~mask_m;
    if (cands == '0) begin
      @(negedge hclk);
      checks++;
      if ({grant, psel, req_done} !== '0) begin
        failures++;
        $display("FAIL %s_masked_idle got=%h exp=0", tag, {grant, psel, req_done});
      end
      cands = pend_vec();
    end
    mask_m = '0;
    win = pick(cands, model_ptr);
    checks++;
    if (win < 0) begin
      failures++;
      $display("FAIL %s_no_request got=none exp=a pending requester", tag);
      return;
    end
    oh = '0;
    oh[win] = 1'b1;
    slave_waits = tmo ? -1 : waits;
    slave_rdata = rd;
    slave_err   = err;

    @(negedge hclk);
    checks++;
    if ({grant, psel, penable, pwrite, paddr, pwdata, req_done} !==
        {oh, sel_m[win], 1'b0, wr_m[win], addr_m[win], wdata_m[win], {NUM_REQ{1'b0}}}) begin
      failures++;
      $display("FAIL %s_setup got=%h exp=%h", tag,
               {grant, psel, penable, pwrite, paddr, pwdata, req_done},
               {oh, sel_m[win], 1'b0, wr_m[win], addr_m[win], wdata_m[win], {NUM_REQ{1'b0}}});
    end

    if (scramble) begin
      req_write[win]                    = ~wr_m[win];
      req_addr[win*ADDR_W +: ADDR_W]    = $urandom;
      req_wdata[win*DATA_W +: DATA_W]   = $urandom;
      req_sel[win*SEL_W +: SEL_W]       = ~sel_m[win];
      if ($urandom_range(0, 3) == 0) req_valid[win] = 1'b0;
      for (int i = 0; i < NUM_REQ; i++)
        if (i != win && pend_m[i] && $urandom_range(0, 3) == 0) begin
          pend_m[i]    = 1'b0;
          req_valid[i] = 1'b0;
        end
    end

    nw = tmo ? TIMEOUT - 1 : waits;
    for (int k = 0; k <= nw; k++) begin
      @(negedge hclk);
      checks++;
      if ({grant, psel, penable, pwrite, paddr, pwdata, req_done} !==
          {oh, sel_m[win], 1'b1, wr_m[win], addr_m[win], wdata_m[win], {NUM_REQ{1'b0}}}) begin
        failures++;
        $display("FAIL %s_access%0d got=%h exp=%h", tag, k,
                 {grant, psel, penable, pwrite, paddr, pwdata, req_done},
                 {oh, sel_m[win], 1'b1, wr_m[win], addr_m[win], wdata_m[win], {NUM_REQ{1'b0}}});
      end
    end

    @(negedge hclk);
    exp_err = tmo ? 1'b1 : err;
    exp_rd  = (tmo || wr_m[win]) ? '0 : rd;
    checks++;
    if ({req_done, req_err, req_rdata, psel, penable, grant} !==
        {oh, exp_err, exp_rd, {SEL_W{1'b0}}, 1'b0, {NUM_REQ{1'b0}}}) begin
      failures++;
      $display("FAIL %s_done got=%h exp=%h", tag,
               {req_done, req_err, req_rdata, psel, penable, grant},
               {oh, exp_err, exp_rd, {SEL_W{1'b0}}, 1'b0, {NUM_REQ{1'b0}}});
    end
    model_ptr   = (win + 1) % NUM_REQ;
    mask_m      = oh;
    last_win    = win;
    pend_m[win] = 1'b0;
    apply_reqs();
  endtask

  task automatic test_reset();
    hresetn = 1'b1;
    #1 hresetn = 1'b0;
    #1;
    checks++;
    if ({req_done, req_err, req_rdata, grant, psel, penable, pwrite, paddr, pwdata} !== '0) begin
      failures++;
      $display("FAIL reset_outputs got=%h exp=0",
               {req_done, req_err, req_rdata, grant, psel, penable, pwrite, paddr, pwdata});
    end
    repeat (2) @(negedge hclk);
    hresetn = 1'b1;
    repeat (3) begin
      @(negedge hclk);
      checks++;
      if ({grant, psel, penable, req_done} !== '0) begin
        failures++;
        $display("FAIL reset_idle got=%h exp=0", {grant, psel, penable, req_done});
      end
    end
  endtask

  task automatic test_single_read();
    do_reset();
    pend_m[0] = 1'b1; wr_m[0] = 1'b0; addr_m[0] = 32'h0000_0100;
    wdata_m[0] = 32'h0; sel_m[0] = 3'b001;
    apply_reqs();
    run_xfer(0, 1'b0, 1'b0, 32'hCAFE_0001, 1'b0, "single_read");
  endtask

  task automatic test_round_robin();
    do_reset();
    new_req(0);
    new_req(1);
    apply_reqs();
    for (int i = 0; i < 4; i++) begin
      run_xfer($urandom_range(0, 2), 1'b0, 1'b0, $urandom, 1'b0, "round_robin");
      checks++;
      if (last_win !== i % 2) begin
        failures++;
        $display("FAIL rr_order%0d got=%0d exp=%0d", i, last_win, i % 2);
      end
      new_req(last_win);
      apply_reqs();
    end
  endtask

  task automatic test_write_waits();
    do_reset();
    pend_m[1] = 1'b1; wr_m[1] = 1'b1; addr_m[1] = 32'h0000_0040;
    wdata_m[1] = 32'hA5A5_A5A5; sel_m[1] = 3'b010;
    apply_reqs();
    run_xfer(3, 1'b0, 1'b0, 32'h1234_5678, 1'b1, "write_waits");
  endtask

  task automatic test_timeout();
    do_reset();
    new_req(0);
    wr_m[0] = 1'b0;
    apply_reqs();
    run_xfer(0, 1'b1, 1'b0, 32'hDEAD_BEEF, 1'b0, "timeout");
  endtask

  task automatic test_slverr();
    do_reset();
    new_req(0);
    wr_m[0] = 1'b0;
    apply_reqs();
    run_xfer(0, 1'b0, 1'b1, 32'h0BAD_0BAD, 1'b0, "slverr");
    new_req(1);
    wr_m[1] = 1'b0;
    apply_reqs();
    run_xfer(1, 1'b0, 1'b0, 32'h600D_600D, 1'b0, "after_err");
  endtask

  task automatic test_reset_mid();
    do_reset();
    new_req(0);
    apply_reqs();
    run_xfer(0, 1'b0, 1'b0, $urandom, 1'b0, "pre_abort");
    new_req(1);
    apply_reqs();
    slave_waits = -1;
    repeat (3) @(negedge hclk);
    checks++;
    if ({grant, psel, penable} !== {2'b10, sel_m[1], 1'b1}) begin
      failures++;
      $display("FAIL abort_in_access got=%h exp=%h", {grant, psel, penable}, {2'b10, sel_m[1], 1'b1});
    end
    #2 hresetn = 1'b0;
    #1;
    checks++;
    if ({grant, psel, penable, req_done} !== '0) begin
      failures++;
      $display("FAIL abort_clear got=%h exp=0", {grant, psel, penable, req_done});
    end
    new_req(0);
    apply_reqs();
    repeat (3) begin
      @(negedge hclk);
      checks++;
      if ({grant, psel, req_done} !== '0) begin
        failures++;
        $display("FAIL abort_hold got=%h exp=0", {grant, psel, req_done});
      end
    end
    hresetn   = 1'b1;
    model_ptr = 0;
    mask_m    = '0;
    run_xfer(1, 1'b0, 1'b0, $urandom, 1'b0, "after_abort");
    checks++;
    if (last_win !== 0) begin
      failures++;
      $display("FAIL abort_ptr got=%0d exp=0", last_win);
    end
    run_xfer(0, 1'b0, 1'b0, $urandom, 1'b0, "after_abort2");
  endtask

  task automatic test_random();
    for (int it = 0; it < 24; it++) begin
      for (int i = 0; i < NUM_REQ; i++)
        if (!pend_m[i] && $urandom_range(0, 1) == 1) new_req(i);
      if (pend_vec() == '0) new_req($urandom_range(0, NUM_REQ - 1));
      apply_reqs();
      run_xfer($urandom_range(0, 3), ($urandom_range(0, 7) == 0), 1'($urandom_range(0, 1)),
               $urandom, 1'b1, "random");
    end
  endtask

  initial begin
    hresetn = 1'b1;
    for (int i = 0; i < NUM_REQ; i++) begin
      pend_m[i] = 1'b0; wr_m[i] = 1'b0; addr_m[i] = '0; wdata_m[i] = '0; sel_m[i] = '0;
    end
    apply_reqs();
    test_reset();
    test_single_read();
    test_round_robin();
    test_write_waits();
    test_timeout();
    test_slverr();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
